dmem_arbiter: RTL and testbench

Single-port data SRAM arbiter placed between the EX-stage load/store unit and the data SRAM, sharing the SRAM with a second master (DMA/debug port). The CPU has default priority. A saturating wait counter guarantees the second master a grant after a bounded number of denied cycles. Returned read data is routed to whichever master owned the access, and a stall request is raised whenever a CPU access is held off.

---
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data SRAM between the EX-stage
// load/store unit (default priority) and a DMA/debug master. A saturating
// wait counter bounds how long the DMA can be starved, and read data is
// steered back to whichever master issued the load one cycle earlier.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU (EX stage) port
  input  logic        cpu_en,
  input  logic [7:0]  cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        stallreq_dmem,
  // DMA / debug port
  input  logic        dma_req,
  input  logic [7:0]  dma_we,
  input  logic [63:0] dma_addr,
  input  logic [63:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [63:0] dma_rdata,
  // SRAM port
  output logic        sram_en,
  output logic [7:0]  sram_we,
  output logic [63:0] sram_addr,
  output logic [63:0] sram_wdata,
  input  logic [63:0] sram_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       rd_owner;   // bit0: CPU load in flight, bit1: DMA load in flight
  logic             dma_win;
  logic             cpu_win;

  // Grant decision: CPU wins unless the DMA has waited MAX_WAIT cycles;
  // everything is gated by rst_n so the SRAM stays quiet during reset.
  always_comb begin
    dma_win       = rst_n & dma_req & (~cpu_en | (wait_cnt == WAIT_SAT));
    cpu_win       = rst_n & cpu_en & ~dma_win;
    dma_gnt       = dma_win;
    stallreq_dmem = rst_n & cpu_en & dma_win;
  end

  // SRAM port mux: owner's fields when granted, all zero when idle.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (dma_win) begin
      sram_en    = 1'b1;
      sram_we    = dma_we;
      sram_addr  = dma_addr;
      sram_wdata = dma_wdata;
    end else if (cpu_win) begin
      sram_en    = 1'b1;
      sram_we    = cpu_we;
      sram_addr  = cpu_addr;
      sram_wdata = cpu_wdata;
    end
  end

  // ---- issue -> return boundary: counter and read ownership ----

  // Starvation counter: counts denied DMA cycles, saturates, and clears on
  // grant or when the DMA withdraws, so the CPU wins right after a forced grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!dma_req || dma_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_SAT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Remember who issued a load this cycle; stores never claim the return path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner <= 2'b00;
    end else begin
      rd_owner <= {dma_win & (dma_we == 8'h00), cpu_win & (cpu_we == 8'h00)};
    end
  end

  // Return steering: SRAM data goes only to the master that owns the read.
  always_comb begin
    cpu_rdata  = rd_owner[0] ? sram_rdata : 64'h0;
    dma_rvalid = rd_owner[1];
    dma_rdata  = rd_owner[1] ? sram_rdata : 64'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Each step drives one cycle of requests
// with the grant the bench expects; read returns are queued at issue and
// checked one cycle later against the SRAM data driven in that cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en;
  logic [7:0]  cpu_we;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        stallreq_dmem;
  logic        dma_req;
  logic [7:0]  dma_we;
  logic [63:0] dma_addr;
  logic [63:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [63:0] dma_rdata;
  logic        sram_en;
  logic [7:0]  sram_we;
  logic [63:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic cpu;
    logic dma;
  } ret_t;
  ret_t ret_q[$];

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stallreq_dmem(stallreq_dmem),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset for n cycles with both masters requesting; every output must be 0.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; cpu_en = 1'b1; cpu_we = 8'h00; cpu_addr = 64'h100;
      cpu_wdata = 64'h1111; dma_req = 1'b1; dma_we = 8'h00; dma_addr = 64'h300;
      dma_wdata = 64'h2222; sram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      chk("rst_sram_en", sram_en, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_wdata", sram_wdata, 0);
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_stall", stallreq_dmem, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dma_rvalid", dma_rvalid, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
    end
    ret_q.delete();
    ret_q.push_back(ret_t'(2'b00));
  endtask

  // One cycle: drive requests, check the return owed from the previous cycle,
  // check this cycle's grant/SRAM port, and queue the return this cycle owes.
  task automatic step(input string tag,
                      input logic ce, input logic [7:0] cwe, input logic [63:0] ca,
                      input logic dr, input logic [7:0] dwe, input logic [63:0] da,
                      input logic [63:0] rd, input logic eg_cpu, input logic eg_dma);
    ret_t e;
    logic [63:0] cwd, dwd;
    cwd = ca ^ 64'hA5A5_0000_0000_5A5A;
    dwd = da ^ 64'h0F0F_F0F0_0F0F_F0F0;
    @(negedge clk);
    rst_n = 1'b1; cpu_en = ce; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dwd; sram_rdata = rd;
    #1;
    if (ret_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty observed=0 expected=1", tag);
      e = ret_t'(2'b00);
    end else begin
      e = ret_q.pop_front();
    end
    chk({tag, "_cpu_rdata"}, cpu_rdata, e.cpu ? rd : 64'h0);
    chk({tag, "_dma_rvalid"}, dma_rvalid, e.dma);
    chk({tag, "_dma_rdata"}, dma_rdata, e.dma ? rd : 64'h0);
    chk({tag, "_dma_gnt"}, dma_gnt, eg_dma);
    chk({tag, "_stall"}, stallreq_dmem, ce & eg_dma);
    chk({tag, "_sram_en"}, sram_en, eg_cpu | eg_dma);
    chk({tag, "_sram_we"}, sram_we, eg_dma ? dwe : (eg_cpu ? cwe : 8'h00));
    chk({tag, "_sram_addr"}, sram_addr, eg_dma ? da : (eg_cpu ? ca : 64'h0));
    chk({tag, "_sram_wdata"}, sram_wdata, eg_dma ? dwd : (eg_cpu ? cwd : 64'h0));
    ret_q.push_back({eg_cpu & (cwe == 8'h00), eg_dma & (dwe == 8'h00)});
  endtask

  initial begin
    rst_n = 1'b0; cpu_en = 1'b0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = '0; dma_addr = '0; dma_wdata = '0; sram_rdata = '0;

    // Reset with both masters requesting, then CPU wins the first cycle.
    do_reset(2);
    step("post_rst", 1, 8'h00, 64'h100, 1, 8'h00, 64'h300, 64'h55, 1, 0);

    // Plain CPU load and its return.
    step("cpu_ld", 1, 8'h00, 64'h100, 0, 8'h00, 64'h0, 64'h77, 1, 0);
    step("cpu_ret", 0, 8'h00, 64'h0, 0, 8'h00, 64'h0, 64'hDEADBEEF, 0, 0);

    // DMA write, no read return afterwards.
    step("dma_wr", 0, 8'h00, 64'h0, 1, 8'hFF, 64'h200, 64'h1, 0, 1);
    step("dma_wr_ret", 0, 8'h00, 64'h0, 0, 8'h00, 64'h0, 64'h2, 0, 0);

    // CPU store: no owner, nothing returned next cycle.
    step("cpu_st", 1, 8'h0F, 64'h180, 0, 8'h00, 64'h0, 64'h3, 1, 0);

    // Saturated contention: DMA forced every 5th cycle (MAX_WAIT=4).
    for (int i = 1; i <= 11; i++) begin
      step($sformatf("sat%0d", i), 1, 8'h00, 64'h1000 + 64'(i * 8),
           1, 8'h00, 64'h300, {$urandom, $urandom}, (i % 5) != 0, (i % 5) == 0);
    end
    step("sat_drain", 0, 8'h00, 64'h0, 0, 8'h00, 64'h0, 64'hCAFE, 0, 0);

    // DMA withdraws before grant: counter clears, CPU keeps winning.
    for (int i = 1; i <= 3; i++)
      step($sformatf("pre%0d", i), 1, 8'h00, 64'h40, 1, 8'h00, 64'h300, 64'(i), 1, 0);
    step("drop", 1, 8'h00, 64'h40, 0, 8'h00, 64'h0, 64'h9, 1, 0);
    for (int i = 1; i <= 4; i++)
      step($sformatf("post_drop%0d", i), 1, 8'h00, 64'h48, 1, 8'h00, 64'h300,
           64'(i + 16), 1, 0);
    step("post_drop5", 1, 8'h00, 64'h48, 1, 8'h00, 64'h300, 64'h99, 0, 1);

    // Granted DMA read killed by a 1-cycle reset pulse: no rvalid afterwards.
    step("dma_rd", 0, 8'h00, 64'h0, 1, 8'h00, 64'h300, 64'h5, 0, 1);
    do_reset(1);
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("resume%0d", i), 1, 8'h00, 64'h500 + 64'(i),
           1, 8'h00, 64'h380, {$urandom, $urandom}, (i % 5) != 0, (i % 5) == 0);
    end
    step("final_drain", 0, 8'h00, 64'h0, 0, 8'h00, 64'h0, 64'hF00D, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
